// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen
// AXI4-Stream master that generates packetised test traffic (for example for
// DMA card-to-host bring-up) with a start/stop/busy/done control handshake.
//
// Parameters:
//   DATA_WIDTH - tdata width in bits (multiple of 8, 8..512)
//   LEN_WIDTH  - width of pkt_len
//   GAP_WIDTH  - width of gap
//
// Ports:
//   clk, resetn          - clock and synchronous active-low reset
//   start, stop          - run request (sampled in IDLE) / abort at packet boundary
//   mode                 - 0 word counter, 1 byte-lane ramp, 2 constant, 3 PRBS
//   pkt_len, num_pkts    - beats per packet (0 illegal), packets per run (0 = continuous)
//   gap                  - idle cycles between packets
//   seed                 - initial pattern value
//   m_axis_*             - AXI4-Stream master (tdata/tvalid/tlast out, tready in)
//   busy, done           - run in progress / one-cycle end-of-run pulse
//
// Build option:
//   AXIS_PATTERN_GEN_PRBS_EN - when defined, mode 3 is a 32-bit Galois LFSR;
//                              otherwise mode 3 behaves as mode 0.
module axis_pattern_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [15:0]           num_pkts,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = GAP_WIDTH'(1);
  localparam logic [15:0]           PKT_ONE  = 16'd1;
  localparam logic [DATA_WIDTH-1:0] PAT_ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] PAT_BYTES = DATA_WIDTH'(DATA_WIDTH / 8);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  beatCnt_q, beatCnt_d;
  logic [15:0]           pktCnt_q, pktCnt_d;
  logic [GAP_WIDTH-1:0]  gapCnt_q, gapCnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  pktLen_q, pktLen_d;
  logic [15:0]           numPkts_q, numPkts_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  // Word counter in mode 0/3-fallback; in mode 1 its low byte is the ramp base.
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic [DATA_WIDTH-1:0] patNext;
  logic                  stopPend_q, stopPend_d;
  logic                  stopNow;

  // Data word for the counter/ramp/constant modes.
  function automatic logic [DATA_WIDTH-1:0] dataOf(input logic [1:0] m,
                                                   input logic [DATA_WIDTH-1:0] pat,
                                                   input logic [DATA_WIDTH-1:0] sd);
    logic [DATA_WIDTH-1:0] r;
    case (m)
      2'd1: begin
        r = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
          r[i*8 +: 8] = pat[7:0] + 8'(i);
        end
      end
      2'd2:    r = sd;
      default: r = pat;
    endcase
    return r;
  endfunction

`ifdef AXIS_PATTERN_GEN_PRBS_EN
  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] seed32, lfsrInit, lfsrAdv;

  // Narrow buses zero-extend the seed into the 32-bit LFSR.
  if (DATA_WIDTH >= 32) begin : gSeedWide
    assign seed32 = seed[31:0];
  end else begin : gSeedNarrow
    assign seed32 = {{(32 - DATA_WIDTH){1'b0}}, seed};
  end

  // An all-zero LFSR would lock up, so a zero seed starts at 1.
  assign lfsrInit = (seed32 == 32'd0) ? 32'd1 : seed32;
  assign lfsrAdv  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);

  function automatic logic [DATA_WIDTH-1:0] lfsrRep(input logic [31:0] s);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = s[i % 32];
    end
    return r;
  endfunction
`endif

  // Mode 1 moves the ramp base by the number of byte lanes; other modes step by one.
  assign patNext = pat_q + ((mode_q == 2'd1) ? PAT_BYTES : PAT_ONE);
  assign stopNow = stopPend_q | stop;

  // Next-state logic: run control, beat/packet/gap counting and pattern advance.
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    beatCnt_d  = beatCnt_q;
    pktCnt_d   = pktCnt_q;
    gapCnt_d   = gapCnt_q;
    mode_d     = mode_q;
    pktLen_d   = pktLen_q;
    numPkts_d  = numPkts_q;
    gap_d      = gap_q;
    seed_d     = seed_q;
    pat_d      = pat_q;
    stopPend_d = stopPend_q;
`ifdef AXIS_PATTERN_GEN_PRBS_EN
    lfsr_d     = lfsr_q;
`endif

    case (state_q)
      IDLE: begin
        stopPend_d = 1'b0;
        if (start && (pkt_len != '0)) begin
          state_d    = SEND;
          mode_d     = mode;
          pktLen_d   = pkt_len;
          numPkts_d  = num_pkts;
          gap_d      = gap;
          seed_d     = seed;
          pat_d      = seed;
          beatCnt_d  = '0;
          pktCnt_d   = '0;
          gapCnt_d   = '0;
          tvalid_d   = 1'b1;
          tlast_d    = (pkt_len == LEN_ONE);
          busy_d     = 1'b1;
          // A stop arriving together with start limits the run to one packet.
          stopPend_d = stop;
          tdata_d    = dataOf(mode, seed, seed);
`ifdef AXIS_PATTERN_GEN_PRBS_EN
          lfsr_d     = lfsrInit;
          if (mode == 2'd3) tdata_d = lfsrRep(lfsrInit);
`endif
        end
      end

      SEND: begin
        stopPend_d = stopNow;
        if (tvalid_q && m_axis_tready) begin
          pat_d   = patNext;
          tdata_d = dataOf(mode_q, patNext, seed_q);
`ifdef AXIS_PATTERN_GEN_PRBS_EN
          lfsr_d  = lfsrAdv;
          if (mode_q == 2'd3) tdata_d = lfsrRep(lfsrAdv);
`endif
          if (tlast_q) begin
            if (((numPkts_q != '0) && ((pktCnt_q + PKT_ONE) == numPkts_q)) || stopNow) begin
              state_d    = IDLE;
              tvalid_d   = 1'b0;
              tlast_d    = 1'b0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              stopPend_d = 1'b0;
            end else begin
              beatCnt_d = '0;
              pktCnt_d  = pktCnt_q + PKT_ONE;
              if (gap_q == '0) begin
                tlast_d = (pktLen_q == LEN_ONE);
              end else begin
                state_d  = GAP;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                gapCnt_d = '0;
              end
            end
          end else begin
            beatCnt_d = beatCnt_q + LEN_ONE;
            tlast_d   = ((beatCnt_q + LEN_ONE) == (pktLen_q - LEN_ONE));
          end
        end
      end

      GAP: begin
        stopPend_d = stopNow;
        if (stopNow) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          stopPend_d = 1'b0;
        end else if (gapCnt_q == (gap_q - GAP_ONE)) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
          tlast_d  = (pktLen_q == LEN_ONE);
        end else begin
          gapCnt_d = gapCnt_q + GAP_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      beatCnt_q  <= '0;
      pktCnt_q   <= '0;
      gapCnt_q   <= '0;
      mode_q     <= '0;
      pktLen_q   <= '0;
      numPkts_q  <= '0;
      gap_q      <= '0;
      seed_q     <= '0;
      pat_q      <= '0;
      stopPend_q <= 1'b0;
`ifdef AXIS_PATTERN_GEN_PRBS_EN
      lfsr_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      beatCnt_q  <= beatCnt_d;
      pktCnt_q   <= pktCnt_d;
      gapCnt_q   <= gapCnt_d;
      mode_q     <= mode_d;
      pktLen_q   <= pktLen_d;
      numPkts_q  <= numPkts_d;
      gap_q      <= gap_d;
      seed_q     <= seed_d;
      pat_q      <= pat_d;
      stopPend_q <= stopPend_d;
`ifdef AXIS_PATTERN_GEN_PRBS_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Testbench for axis_pattern_gen (64-bit data bus).
module tb_axis_pattern_gen;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          resetn, start, stop;
  logic [1:0]    mode;
  logic [LW-1:0] pktLen;
  logic [15:0]   numPkts;
  logic [GW-1:0] gapLen;
  logic [DW-1:0] seed;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready, busy, done;

  axis_pattern_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .mode(mode),
    .pkt_len(pktLen), .num_pkts(numPkts), .gap(gapLen), .seed(seed),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tready(tready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    logic [LW-1:0] len;
    logic [15:0]   num;
    logic [GW-1:0] gap;
    int            readyMode;
    bit            stopAtStart;
    logic [DW-1:0] firstData;
    int            beats;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  vec_t  vecs[8];
  beat_t expQ[$];

  int compared = 0;
  int mismatched = 0;
  int readyMode = 0;
  int runBeats = 0;
  int expGap = 0;
  int idleCnt = 0;
  bit monEnable = 1'b1;
  bit sawLast = 1'b0;
  bit doneNext = 1'b0;
  bit doneAfter = 1'b0;
  bit holdPending = 1'b0;
  logic [DW-1:0] holdData;
  logic          holdLast;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Reference model: push every beat the run should produce.
  task automatic pushRun(input logic [1:0] m, input logic [DW-1:0] sd,
                         input logic [LW-1:0] len, input int npk);
    int k = 0;
    logic [31:0] lfsr;
    logic [7:0] base;
    beat_t b;
    lfsr = (sd[31:0] == 32'd0) ? 32'd1 : sd[31:0];
    for (int p = 0; p < npk; p++) begin
      for (int i = 0; i < int'(len); i++) begin
        case (m)
          2'd1: begin
            base = sd[7:0] + 8'(k * 8);
            for (int l = 0; l < 8; l++) b.data[l*8 +: 8] = base + 8'(l);
          end
          2'd2: b.data = sd;
`ifdef AXIS_PATTERN_GEN_PRBS_EN
          2'd3: b.data = {lfsr, lfsr};
`endif
          default: b.data = sd + DW'(k);
        endcase
        b.last = (i == int'(len) - 1);
        expQ.push_back(b);
        lfsr = lfsrStep(lfsr);
        k++;
      end
    end
  endtask

  // Ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: tready = 1'b1;
        1: tready = ~tready;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    beat_t e;
    if (monEnable) begin
      if (doneAfter) begin
        check("donePulseEnd", 64'(done), 64'd0);
        doneAfter = 1'b0;
      end
      if (doneNext) begin
        check("doneHigh", 64'(done), 64'd1);
        check("busyLowAtDone", 64'(busy), 64'd0);
        check("validLowAtDone", 64'(tvalid), 64'd0);
        doneNext = 1'b0;
        doneAfter = 1'b1;
      end
      if (holdPending) begin
        check("holdValid", 64'(tvalid), 64'd1);
        check("holdData", tdata, holdData);
        check("holdLast", 64'(tlast), 64'(holdLast));
        holdPending = 1'b0;
      end
      if (sawLast) begin
        if (tvalid) begin
          check("gapCycles", 64'(idleCnt), 64'(expGap));
          sawLast = 1'b0;
        end else begin
          idleCnt++;
        end
      end
      if (tvalid && tready) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedBeat: got data %h, required no beat", tdata);
        end else begin
          e = expQ.pop_front();
          check("beatData", tdata, e.data);
          check("beatLast", 64'(tlast), 64'(e.last));
          runBeats++;
          if (expQ.size() == 0) doneNext = 1'b1;
          else if (e.last) begin
            sawLast = 1'b1;
            idleCnt = 0;
          end
        end
      end else if (tvalid && !tready) begin
        holdPending = 1'b1;
        holdData = tdata;
        holdLast = tlast;
      end
    end
  end

  task automatic waitDone(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL doneTimeout: got no done in %0d cycles, required done", budget);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic applyStimulus(input vec_t v);
    readyMode = v.readyMode;
    runBeats = 0;
    expGap = int'(v.gap);
    sawLast = 1'b0;
    pushRun(v.mode, v.seed, v.len, v.stopAtStart ? 1 : int'(v.num));
    mode = v.mode;
    seed = v.seed;
    pktLen = v.len;
    numPkts = v.num;
    gapLen = v.gap;
    start = 1'b1;
    stop = v.stopAtStart;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check("startBusy", 64'(busy), 64'd1);
    check("startValid", 64'(tvalid), 64'd1);
    check("firstData", tdata, v.firstData);
  endtask

  task automatic checkOutput(input vec_t v);
    waitDone(400);
    check("beatCount", 64'(runBeats), 64'(v.beats));
    check("queueEmpty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{2'd0, 64'd0, 16'd4, 16'd2, 8'd0, 0, 1'b0, 64'd0, 8};
    vecs[1] = '{2'd0, 64'd0, 16'd4, 16'd2, 8'd0, 1, 1'b0, 64'd0, 8};
    vecs[2] = '{2'd1, 64'hFC, 16'd2, 16'd2, 8'd3, 0, 1'b0, 64'h03020100_FFFEFDFC, 4};
    vecs[3] = '{2'd2, 64'hDEADBEEF_12345678, 16'd3, 16'd2, 8'd1, 2, 1'b0, 64'hDEADBEEF_12345678, 6};
    vecs[4] = '{2'd0, 64'hFFFFFFFF_FFFFFFFE, 16'd1, 16'd3, 8'd2, 0, 1'b0, 64'hFFFFFFFF_FFFFFFFE, 3};
`ifdef AXIS_PATTERN_GEN_PRBS_EN
    vecs[5] = '{2'd3, 64'd1, 16'd2, 16'd1, 8'd0, 0, 1'b0, 64'h00000001_00000001, 2};
`else
    vecs[5] = '{2'd3, 64'd1, 16'd2, 16'd1, 8'd0, 0, 1'b0, 64'd1, 2};
`endif
    vecs[6] = '{2'd1, 64'h10, 16'd3, 16'd2, 8'd0, 2, 1'b0, 64'h17161514_13121110, 6};
    vecs[7] = '{2'd0, 64'd100, 16'd2, 16'd3, 8'd2, 1, 1'b1, 64'd100, 2};

    resetn = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; seed = '0;
    pktLen = '0; numPkts = '0; gapLen = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("resetData", tdata, 64'd0);
    check("resetValid", 64'(tvalid), 64'd0);
    check("resetLast", 64'(tlast), 64'd0);
    check("resetBusy", 64'(busy), 64'd0);
    check("resetDone", 64'(done), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);

    // Consecutive runs; each start lands in the previous run's done cycle.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v]);
      checkOutput(vecs[v]);
    end
    repeat (2) @(negedge clk);

    // pkt_len of 0 must not start a run.
    readyMode = 0;
    pktLen = '0; numPkts = 16'd1; mode = '0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("zeroLenBusy", 64'(busy), 64'd0);
    check("zeroLenValid", 64'(tvalid), 64'd0);

    // Continuous run stopped during beat 2 of the third packet.
    runBeats = 0; expGap = 0; sawLast = 1'b0;
    pushRun(2'd0, 64'd0, 16'd5, 3);
    mode = 2'd0; seed = '0; pktLen = 16'd5; numPkts = 16'd0; gapLen = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (runBeats < 12 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (runBeats < 12) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL stopWait: got %0d beats, required 12", runBeats);
    end
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    waitDone(100);
    check("stopBeatCount", 64'(runBeats), 64'd15);
    check("stopQueueEmpty", 64'(expQ.size()), 64'd0);
    repeat (10) @(negedge clk);
    check("noFourthPacket", 64'(tvalid), 64'd0);
    check("idleAfterStop", 64'(busy), 64'd0);

    // Reset in the middle of a packet.
    monEnable = 1'b0;
    mode = 2'd0; seed = 64'd5; pktLen = 16'd8; numPkts = 16'd1; gapLen = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midPacketValid", 64'(tvalid), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("midRstData", tdata, 64'd0);
    check("midRstValid", 64'(tvalid), 64'd0);
    check("midRstLast", 64'(tlast), 64'd0);
    check("midRstBusy", 64'(busy), 64'd0);
    check("midRstDone", 64'(done), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    expQ.delete();
    sawLast = 1'b0; doneNext = 1'b0; doneAfter = 1'b0; holdPending = 1'b0;
    monEnable = 1'b1;

    // Recovery after reset.
    applyStimulus(vecs[0]);
    checkOutput(vecs[0]);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
